lx32_muldiv: RTL and testbench
==============================

// Module: lx32_muldiv
// PURPOSE
//  Sequential RV32M multiply/divide unit; the multi-cycle companion to the combinational ALU in the EX stage.
//  Takes one operation per valid/ready handshake and runs a radix-2 iterative shift-add multiply or restoring divide.
//  Returns the result with its destination tag on a valid/ready output. EX stalls on in_ready=0 and kills on flush.
// PARAMETERS
//  WIDTH           32  operand/result width; any value >= 4 is legal.
//  TAG_W            5  width of the opaque tag (rd index) passed from in_tag to out_tag.
//  BYPASS_SPECIAL   1  1: divide-by-zero and signed overflow finish 1 cycle after accept; 0: full latency.
// PORTS
//  clk        in   1       clock; all logic on the rising edge.
//  rst_n      in   1       synchronous, active-low reset.
//  in_valid   in   1       request valid.
//  in_ready   out  1       unit can accept; equals (state==IDLE).
//  in_op      in   3       funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
//  in_a       in   WIDTH   rs1 (multiplicand / dividend).
//  in_b       in   WIDTH   rs2 (multiplier / divisor).
//  in_tag     in   TAG_W   tag returned with the result.
//  flush      in   1       kill any in-flight or unconsumed operation.
//  out_valid  out  1       result valid.
//  out_ready  in   1       consumer accepts the result.
//  out_result out  WIDTH   result.
//  out_tag    out  TAG_W   tag of the operation in out_result.
//  busy       out  1       state != IDLE.
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=IDLE, out_valid=0, out_result=0, out_tag=0, counter=0. in_ready=1 from the next cycle.
//  FSM: IDLE -> BUSY on accept (in_valid & in_ready); BUSY -> DONE when the counter expires; DONE -> IDLE on out_valid & out_ready.
//   IDLE -> DONE directly for bypassed special cases when BYPASS_SPECIAL=1.
//  Accept latches op, operands, tag and sign flags. Signed ops convert operands to magnitudes before iterating.
//  BUSY runs exactly WIDTH iterations; counter loads WIDTH-1 and counts down to 0.
//   out_valid rises WIDTH+1 edges after the accepting edge (33 for WIDTH=32).
//  Multiply: 2*WIDTH-bit product, one multiplier bit per cycle, then sign correction on entry to DONE.
//   MUL returns the low WIDTH bits. MULH/MULHSU/MULHU return the high WIDTH bits.
//   MULH: both operands signed. MULHSU: a signed, b unsigned. MULHU: both unsigned.
//  Divide: restoring, one quotient bit per cycle, unsigned magnitudes.
//   Quotient is negated if the operand signs differ (DIV). Remainder takes the sign of the dividend (REM).
//  Special cases follow the RISC-V spec exactly:
//   b==0: DIV/DIVU -> all ones; REM/REMU -> a.
//   DIV with a=most-negative and b=-1 -> a; REM in the same case -> 0.
//   These complete one edge after accept if BYPASS_SPECIAL=1; otherwise at full latency.
//  In DONE, out_valid is held high and out_result/out_tag are stable until out_ready.
//   in_ready=0 throughout BUSY and DONE; in_valid is ignored there.
//   On handshake: out_valid=0 and state=IDLE at the next edge.
//   A new accept is possible at the edge after that; there is no same-cycle turnaround.
//  flush=1 at an edge: state=IDLE, out_valid=0, and the result is discarded in any state.
//   flush has priority over accept and over the output handshake. An accept in the same cycle as flush is dropped.
//  rst_n=0 mid-operation behaves like reset; no result is emitted.
//  out_result is only meaningful while out_valid=1. In IDLE it holds its last value.
// TESTING (WIDTH=32, BYPASS_SPECIAL=1, out_ready=1 unless stated)
//  1. MUL a=7, b=0xFFFFFFFD, tag=5 -> out_result=0xFFFFFFEB, out_tag=5; out_valid exactly 33 edges after accept, high for 1 cycle.
//  2. MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
//  3. DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF; REMU 10/3 -> 1.
//  4. DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
//     All four: out_valid 1 edge after accept.
//  5. out_ready=0 for 10 cycles after out_valid: out_valid, out_result and out_tag are stable; in_ready=0; a pulsed in_valid is not accepted.
//     Raise out_ready: handshake, then in_ready=1 on the next cycle.
//  6. flush on the 10th BUSY cycle: no out_valid ever appears, in_ready=1 next cycle, and the next MUL 3*4 -> 12.
//     Repeat with rst_n=0 mid-BUSY: same result.

Source files
------------

// File: rtl/lx32_muldiv.sv
// Sequential RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one operation at a time behind valid/ready handshakes, with optional fast path for divide special cases.
module lx32_muldiv #(
    parameter int WIDTH          = 32,
    parameter int TAG_W          = 5,
    parameter bit BYPASS_SPECIAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_r, state_next_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [2:0]             op_r;
    logic                   neg_r;
    logic [WIDTH-1:0]       mag_r;
    logic [2*WIDTH-1:0]     work_r;
    logic [WIDTH-1:0]       res_r;
    logic [TAG_W-1:0]       tag_r;

    logic                   accept_s;
    logic                   a_signed_s, b_signed_s, a_neg_s, b_neg_s;
    logic [WIDTH-1:0]       a_mag_s, b_mag_s;
    logic                   b_zero_s, ovf_s, bypass_s;
    logic [WIDTH-1:0]       special_res_s;
    logic [WIDTH:0]         mul_sum_s, div_trial_s;
    logic [2*WIDTH-1:0]     mul_next_s, div_next_s, work_next_s, prod_s;
    logic [WIDTH-1:0]       div_sel_s, final_res_s;

    assign accept_s    = in_valid && (state_r == IDLE) && !flush;
    // MULHU and the unsigned divides treat rs1 as unsigned; rs2 is signed only for MUL/MULH and DIV/REM.
    assign a_signed_s  = in_op[2] ? ~in_op[0] : (in_op[1:0] != 2'b11);
    assign b_signed_s  = in_op[2] ? ~in_op[0] : ~in_op[1];
    assign a_neg_s     = a_signed_s && in_a[WIDTH-1];
    assign b_neg_s     = b_signed_s && in_b[WIDTH-1];
    assign a_mag_s     = a_neg_s ? (~in_a + {{(WIDTH-1){1'b0}}, 1'b1}) : in_a;
    assign b_mag_s     = b_neg_s ? (~in_b + {{(WIDTH-1){1'b0}}, 1'b1}) : in_b;

    assign b_zero_s    = (in_b == {WIDTH{1'b0}});
    assign ovf_s       = ~in_op[0] && (in_a == {1'b1, {(WIDTH-1){1'b0}}}) && (in_b == {WIDTH{1'b1}});
    assign bypass_s    = BYPASS_SPECIAL && in_op[2] && (b_zero_s || ovf_s);
    assign special_res_s = b_zero_s ? (in_op[1] ? in_a : {WIDTH{1'b1}})
                                    : (in_op[1] ? {WIDTH{1'b0}} : in_a);

    // One iteration step: multiply adds the multiplicand on the multiplier LSB then shifts right;
    // divide shifts {rem,quo} left and keeps the trial subtraction when it does not go negative.
    assign mul_sum_s   = {1'b0, work_r[2*WIDTH-1:WIDTH]} + (work_r[0] ? {1'b0, mag_r} : {(WIDTH+1){1'b0}});
    assign mul_next_s  = {mul_sum_s, work_r[WIDTH-1:1]};
    assign div_trial_s = {work_r[2*WIDTH-1:WIDTH], work_r[WIDTH-1]} - {1'b0, mag_r};
    assign div_next_s  = div_trial_s[WIDTH] ? {work_r[2*WIDTH-2:0], 1'b0}
                                            : {div_trial_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b1};
    assign work_next_s = op_r[2] ? div_next_s : mul_next_s;

    assign prod_s      = neg_r ? (~work_next_s + {{(2*WIDTH-1){1'b0}}, 1'b1}) : work_next_s;
    assign div_sel_s   = op_r[1] ? work_next_s[2*WIDTH-1:WIDTH] : work_next_s[WIDTH-1:0];
    assign final_res_s = op_r[2] ? (neg_r ? (~div_sel_s + {{(WIDTH-1){1'b0}}, 1'b1}) : div_sel_s)
                                 : ((op_r[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH]);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; flush overrides accept and the output handshake.
    always_comb begin
        state_next_s = state_r;
        if (flush) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_next_s = bypass_s ? DONE : BUSY;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                BUSY: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = BUSY;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = DONE;
                    end
                end
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Output decode from the state register.
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            IDLE:    in_ready = 1'b1;
            BUSY:    busy = 1'b1;
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r  <= {CNT_W{1'b0}};
            op_r   <= 3'b000;
            neg_r  <= 1'b0;
            mag_r  <= {WIDTH{1'b0}};
            work_r <= {(2*WIDTH){1'b0}};
            res_r  <= {WIDTH{1'b0}};
            tag_r  <= {TAG_W{1'b0}};
        end else if (flush) begin
            cnt_r  <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            op_r  <= in_op;
            tag_r <= in_tag;
            cnt_r <= CNT_W'(WIDTH - 1);
            // Divide by zero must leave the quotient all ones, so it is never negated.
            neg_r <= (in_op[2] && in_op[1]) ? a_neg_s : ((a_neg_s ^ b_neg_s) && !(in_op[2] && b_zero_s));
            if (in_op[2]) begin
                mag_r  <= b_mag_s;
                work_r <= {{WIDTH{1'b0}}, a_mag_s};
            end else begin
                mag_r  <= a_mag_s;
                work_r <= {{WIDTH{1'b0}}, b_mag_s};
            end
            if (bypass_s) begin
                res_r <= special_res_s;
            end
        end else if (state_r == BUSY) begin
            work_r <= work_next_s;
            if (cnt_r == {CNT_W{1'b0}}) begin
                res_r <= final_res_s;
            end else begin
                cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign out_result = res_r;
    assign out_tag    = tag_r;

endmodule

// File: tb/tb_lx32_muldiv.sv
// Directed bench for lx32_muldiv: arithmetic vectors, special cases, back-pressure, flush and reset.
module tb_lx32_muldiv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a, in_b;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        busy;

    int checks = 0;
    int errors = 0;

    lx32_muldiv #(.WIDTH(32), .TAG_W(5), .BYPASS_SPECIAL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one request in the cycle before an edge; returns #1 after the accepting edge.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] tg, input string name);
        @(negedge clk);
        check_val({name, " in_ready"}, in_ready, 1);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tg;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Latency counts edges with the accepting edge as the first one.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tg, input logic [31:0] exp, input int exp_lat,
                          input string name);
        int lat;
        start_op(op, a, b, tg, name);
        wait_result(lat);
        check_val({name, " latency"}, lat, exp_lat);
        check_val({name, " result"}, out_result, exp);
        check_val({name, " tag"}, out_tag, tg);
        @(posedge clk); #1;
        check_val({name, " valid_drop"}, out_valid, 0);
        check_val({name, " ready_back"}, in_ready, 1);
    endtask

    task automatic kill_test(input bit use_reset, input string name);
        int seen;
        start_op(3'b000, 32'd6, 32'd7, 5'd3, name);
        repeat (9) @(posedge clk);
        @(negedge clk);
        if (use_reset) rst_n = 1'b0; else flush = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; flush = 1'b0;
        check_val({name, " in_ready"}, in_ready, 1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check_val({name, " no_valid"}, seen, 0);
        run_op(3'b000, 32'd3, 32'd4, 5'd1, 32'd12, 33, {name, " mul3x4"});
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; in_op = 3'b000; in_a = 32'd0; in_b = 32'd0;
        in_tag = 5'd0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        check_val("reset out_valid", out_valid, 0);
        check_val("reset out_result", out_result, 0);
        check_val("reset out_tag", out_tag, 0);
        check_val("reset in_ready", in_ready, 1);
        check_val("reset busy", busy, 0);
        @(negedge clk); rst_n = 1'b1;

        run_op(3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33, "mul");
        run_op(3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 33, "mulh");
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 33, "mulhu");
        run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 33, "mulhsu");
        run_op(3'b100, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 33, "div");
        run_op(3'b110, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 33, "rem");
        run_op(3'b101, 32'hFFFFFFFF, 32'd2,        5'd11, 32'h7FFFFFFF, 33, "divu");
        run_op(3'b111, 32'd10,       32'd3,        5'd12, 32'd1,        33, "remu");
        run_op(3'b100, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1,  "div0");
        run_op(3'b111, 32'd5,        32'd0,        5'd14, 32'd5,        1,  "remu0");
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1,  "divovf");
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1,  "removf");

        // Back-pressure: result held for 10 cycles while a stray request is ignored.
        out_ready = 1'b0;
        start_op(3'b000, 32'd3, 32'd5, 5'd9, "hold");
        wait_result(lat);
        check_val("hold latency", lat, 33);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                @(negedge clk);
                in_valid = 1'b1; in_op = 3'b100; in_a = 32'd5; in_b = 32'd0; in_tag = 5'd30;
                @(posedge clk); #1;
                in_valid = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
            check_val("hold out_valid", out_valid, 1);
            check_val("hold out_result", out_result, 32'd15);
            check_val("hold out_tag", out_tag, 5'd9);
            check_val("hold in_ready", in_ready, 0);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        check_val("hold handshake valid", out_valid, 0);
        check_val("hold handshake ready", in_ready, 1);
        repeat (3) @(posedge clk); #1;
        check_val("hold stray ignored", out_valid, 0);

        kill_test(1'b0, "flush");
        kill_test(1'b1, "reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
